seg_scan_controller: RTL and testbench
======================================

# seg_scan_controller

Time-multiplexing scan controller for the board's 4-digit common-anode seven-segment display. Shares the single cathode bus between four digits by stepping through them on an internal dwell counter, inserting a short all-off blanking gap between digits to suppress ghosting. New display contents are double-buffered and take effect only at a frame boundary, so digits never tear mid-scan. Sits between the top-level datapath (which supplies hex values) and the display pins.

## Interface
- DWELL_CYCLES, 131072: clock cycles each digit is driven per visit; ≥1.
- BLANK_CYCLES, 16: clock cycles with all anodes off before each digit; ≥1.
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Digit_Data  input  16  four hex nibbles; [3:0] drives digit 0, [15:12] drives digit 3.
- Digit_En  input  4  per-digit enable; 0 keeps that digit dark.
- Dp_In  input  4  per-digit decimal point; 1 lights it.
- Load  input  1  single-cycle strobe; captures Digit_Data/Digit_En/Dp_In into the shadow register.
- Pending  output  1  shadow holds data not yet applied.
- Frame_Tick  output  1  one-cycle pulse on each digit 3→0 wrap.
- An  output  4  anodes, active-low; An[i] selects digit i.
- Seg  output  7  cathodes, active-low; Seg[0]=a … Seg[6]=g.
- Dp  output  1  decimal-point cathode, active-low.

## Operation
- Registers: shadow {data, en, dp}, active {data, en, dp}, digit index idx (2 bits), cycle counter cnt (width $clog2(max(DWELL_CYCLES,BLANK_CYCLES))), state.
- Reset values: state=BLANK, idx=0, cnt=0, active and shadow all 0, Pending=0, Frame_Tick=0, An=4'b1111, Seg=7'b1111111, Dp=1. Display dark until first applied Load.
- FSM:
  - BLANK: An=1111, Seg=1111111, Dp=1. Count cnt 0..BLANK_CYCLES-1; on last count go SHOW, cnt←0.
  - SHOW: An[idx]=0 iff active.en[idx], else An=1111; Seg=hex decode of active nibble idx; Dp=~active.dp[idx] (forced 1 if digit disabled). Count 0..DWELL_CYCLES-1; on last count go BLANK, cnt←0, idx←idx+1 (mod 4).
- Frame wrap: SHOW exit with idx=3. On that edge, Frame_Tick=1 for one cycle; if Pending=1, active←shadow and Pending←0.
- Load: shadow←inputs, Pending←1. Load while Pending=1 overwrites shadow (last write wins).
- Load coinciding with the wrap edge: active takes the old shadow (only if Pending was 1); new inputs go to shadow; Pending ends 1; applied at next wrap.
- Hex decode (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- All outputs registered; An, Seg, Dp change on the same edge — never an enabled anode with stale cathodes.
- Edge 1 = first rising edge after Reset_n deasserts. Digit 0 drives from edge BLANK_CYCLES to edge BLANK_CYCLES+DWELL_CYCLES; each digit slot = BLANK_CYCLES+DWELL_CYCLES cycles; frame = 4× that.
- Load-to-display latency: up to one frame plus BLANK_CYCLES; zero-cost if issued before the wrap edge.
- Reset_n low mid-frame: all outputs return to reset values immediately (asynchronous); shadow and Pending cleared.
- Inputs other than Load are sampled only on the Load cycle.

## Test plan
- Params DWELL_CYCLES=8, BLANK_CYCLES=2. Reset, no Load -> An=1111, Seg=1111111, Dp=1 for 200 cycles; Frame_Tick pulses every 40 cycles.
- Load Digit_Data=16'h3210, Digit_En=4'hF, Dp_In=4'b0100 at cycle 5 -> Pending=1 until first wrap (edge 40); next frame An cycles 1110/1101/1011/0111 for 8 cycles each with Seg 1000000/1111001/0100100/0110000, Dp=0 only on digit 2; 2-cycle 1111 gaps between.
- Digit_En=4'b1010 -> digits 0 and 2 slots show An=1111; digits 1 and 3 light normally.
- Two Loads (16'hAAAA then 16'hBEEF) within one frame -> only BEEF ever displayed.
- Load 16'h1111 on the exact wrap edge with earlier pending 16'h2222 -> next frame shows 2222, following frame 1111, Pending drops at second wrap.
- Assert Reset_n low during digit 2 SHOW -> An=1111 same cycle without clock; after release scan restarts at digit 0, display dark until new Load applied.

Source files
------------

// File: rtl/seg_scan_controller_if.sv
// Bus between the datapath and the seven-segment scan controller.
// master = datapath side, slave = controller side.
interface seg_scan_controller_if;
  logic [15:0] Digit_Data;
  logic [3:0]  Digit_En;
  logic [3:0]  Dp_In;
  logic        Load;
  logic        Pending;
  logic        Frame_Tick;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  modport master (
    output Digit_Data, Digit_En, Dp_In, Load,
    input  Pending, Frame_Tick, An, Seg, Dp
  );

  modport slave (
    input  Digit_Data, Digit_En, Dp_In, Load,
    output Pending, Frame_Tick, An, Seg, Dp
  );
endinterface

// File: rtl/seg_scan_controller.sv
// 4-digit common-anode seven-segment scanner with blanking gaps and
// frame-synchronous double-buffered display contents.
module seg_scan_controller #(
  parameter int DWELL_CYCLES = 131072,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  seg_scan_controller_if.slave bus
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  dp;
  } disp_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  disp_t         act, act_n, sh, sh_n;
  logic          pend, pend_n;
  logic          wrap;
  logic [3:0]    an_q, an_n;
  logic [6:0]    seg_q, seg_n;
  logic          dp_q, dp_n, ft_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    act_n   = act;
    sh_n    = sh;
    pend_n  = pend;
    wrap    = 1'b0;
    an_n    = 4'hF;
    seg_n   = 7'h7F;
    dp_n    = 1'b1;

    case (state)
      BLANK: if (cnt == BLAST) begin
        state_n = SHOW;
        cnt_n   = '0;
      end
      SHOW: if (cnt == DLAST) begin
        state_n = BLANK;
        cnt_n   = '0;
        idx_n   = idx + 2'd1;
        wrap    = (idx == 2'd3);
      end
      default: state_n = BLANK;
    endcase

    // Old shadow is committed before a same-edge Load refills it.
    if (wrap && pend) begin
      act_n  = sh;
      pend_n = 1'b0;
    end
    if (bus.Load) begin
      sh_n   = '{data: bus.Digit_Data, en: bus.Digit_En, dp: bus.Dp_In};
      pend_n = 1'b1;
    end

    // Outputs are decoded from next-state values so An/Seg/Dp flip together.
    if (state_n == SHOW) begin
      seg_n = hex7(act_n.data[{idx_n, 2'b00} +: 4]);
      if (act_n.en[idx_n]) begin
        an_n[idx_n] = 1'b0;
        dp_n        = ~act_n.dp[idx_n];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= BLANK;
      idx   <= '0;
      cnt   <= '0;
      act   <= '0;
      sh    <= '0;
      pend  <= 1'b0;
      ft_q  <= 1'b0;
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      act   <= act_n;
      sh    <= sh_n;
      pend  <= pend_n;
      ft_q  <= wrap;
      an_q  <= an_n;
      seg_q <= seg_n;
      dp_q  <= dp_n;
    end
  end

  assign bus.Pending    = pend;
  assign bus.Frame_Tick = ft_q;
  assign bus.An         = an_q;
  assign bus.Seg        = seg_q;
  assign bus.Dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: timeline model of the scan pushes expected outputs per edge,
// an independent monitor pops and compares just after each rising edge.
module tb_seg_scan_controller;
  localparam int D = 8;
  localparam int B = 2;
  localparam int S = D + B;
  localparam int F = 4 * S;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  seg_scan_controller_if bus();

  seg_scan_controller #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference state: edges since reset plus active/shadow contents.
  int          e;
  logic [15:0] a_data, s_data;
  logic [3:0]  a_en, a_dp, s_en, s_dp;
  logic        pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (model edge %0d, t=%0t)", name, act, req, e, $time);
    end
  endtask

  task automatic model_reset();
    e = 0;
    a_data = '0; a_en = '0; a_dp = '0;
    s_data = '0; s_en = '0; s_dp = '0;
    pend = 1'b0;
  endtask

  // Drive one edge's inputs, advance the model across that edge, push expectation.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] en,
                       input logic [3:0] dp);
    exp_t x;
    int r, k, o;
    logic wrap;
    bus.Load       = ld;
    bus.Digit_Data = ld ? d  : 16'($urandom);
    bus.Digit_En   = ld ? en : 4'($urandom);
    bus.Dp_In      = ld ? dp : 4'($urandom);
    e++;
    wrap = (e % F == 0);
    if (wrap && pend) begin
      a_data = s_data; a_en = s_en; a_dp = s_dp;
      pend = 1'b0;
    end
    if (ld) begin
      s_data = d; s_en = en; s_dp = dp;
      pend = 1'b1;
    end
    r = e % F; k = r / S; o = r % S;
    x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1;
    x.pend = pend; x.ft = wrap;
    if (o >= B) begin
      x.seg = HEX[a_data[k*4 +: 4]];
      if (a_en[k]) begin
        x.an[k] = 1'b0;
        x.dp    = ~a_dp[k];
      end
    end
    q.push_back(x);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0);
  endtask

  // Idle until the next cycle() lands on frame position pos.
  task automatic idle_to(input int pos);
    for (int i = 0; i < F && ((e + 1) % F) != pos; i++) cycle(1'b0, '0, '0, '0);
  endtask

  initial begin : monitor
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("an",      32'(bus.An),         32'(x.an));
        chk("seg",     32'(bus.Seg),        32'(x.seg));
        chk("dp",      32'(bus.Dp),         32'(x.dp));
        chk("pending", 32'(bus.Pending),    32'(x.pend));
        chk("ftick",   32'(bus.Frame_Tick), 32'(x.ft));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stim
    bus.Load = 1'b0; bus.Digit_Data = '0; bus.Digit_En = '0; bus.Dp_In = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_an",   32'(bus.An),         32'hF);
    chk("rst_seg",  32'(bus.Seg),        32'h7F);
    chk("rst_dp",   32'(bus.Dp),         32'h1);
    chk("rst_pend", 32'(bus.Pending),    32'h0);
    chk("rst_ft",   32'(bus.Frame_Tick), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Dark display with free-running frame ticks.
    idle(200);

    // Basic load mid-frame.
    idle_to(5);
    cycle(1'b1, 16'h3210, 4'hF, 4'b0100);
    idle(2 * F);

    // Partial enables.
    cycle(1'b1, 16'h9876, 4'b1010, 4'b1111);
    idle(2 * F);

    // Two loads in one frame: last write wins.
    idle_to(3);
    cycle(1'b1, 16'hAAAA, 4'hF, 4'b0001);
    idle(7);
    cycle(1'b1, 16'hBEEF, 4'hF, 4'b1000);
    idle(2 * F);

    // Load on the exact wrap edge with an earlier pending value.
    idle_to(20);
    cycle(1'b1, 16'h2222, 4'hF, 4'b0010);
    idle_to(0);
    cycle(1'b1, 16'h1111, 4'hF, 4'b0100);
    idle(2 * F + 5);

    // Randomized loads.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0)
        cycle(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        cycle(1'b0, '0, '0, '0);
    end

    // Known lit content, then async reset during digit 2 SHOW.
    cycle(1'b1, 16'h5A5A, 4'hF, 4'hF);
    idle_to(0);
    idle(2 * S + B + 3);
    chk("pre_rst_an", 32'(bus.An), 32'hB);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("arst_an",   32'(bus.An),         32'hF);
    chk("arst_seg",  32'(bus.Seg),        32'h7F);
    chk("arst_dp",   32'(bus.Dp),         32'h1);
    chk("arst_pend", 32'(bus.Pending),    32'h0);
    chk("arst_ft",   32'(bus.Frame_Tick), 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    model_reset();
    Reset_n = 1'b1;
    idle(2 * F);
    cycle(1'b1, 16'hC0DE, 4'hF, 4'b0000);
    idle(2 * F);

    @(posedge Clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
